load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle load/store sequencer between the CPU datapath (control unit, MDR, register B) and the single-port synchronous data memory. It accepts one load or store request, performs byte/halfword/word lane extraction with sign extension for loads and read-modify-write for sub-word stores, and checks alignment. It returns a one-cycle response carrying the loaded word for MDR and an error flag for the exception path.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present; sampled only in IDLE.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  LW=0, LH=1, LB=2, SW=4, SH=5, SB=6; other codes are treated as LW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned access; qualified by resp_valid.
- mem_addr  out  32  word address, always `{addr[31:2],2'b00}`.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word, valid the cycle after mem_addr is presented.

## Operation
- Byte lanes are little-endian: byte k = bits [8k+7:8k], with k = addr[1:0].
- Accept occurs when req_valid && req_ready. On accept, op, addr and wdata are registered.
- Alignment rules:
  - LW/SW require addr[1:0]=0.
  - LH/SH require addr[0]=0.
  - A violation goes to RESP with the error set and no memory access.
- States: IDLE, RD, CAP, RMW_RD, MERGE, WR, RESP.
- Loads: IDLE→RD→CAP→RESP→IDLE.
  - RD drives mem_addr.
  - In CAP, the selected lane is extracted from mem_rdata, sign-extended (LB: byte; LH: halfword at addr[1]), and latched into resp_rdata.
- SW: IDLE→WR→RESP→IDLE. WR drives mem_wr=1 and mem_wdata=wdata.
- SB/SH: IDLE→RMW_RD→MERGE→WR→RESP→IDLE.
  - MERGE replaces the target lane(s) of mem_rdata with wdata[7:0] or wdata[15:0] and latches the merged word.
  - WR writes the merged word.
- mem_wr is 1 only in WR, for exactly one cycle per store. It is never asserted for loads or errors.
- mem_addr and mem_wdata hold their registered values in all non-IDLE states. Both are 0 in IDLE.
- resp_valid, resp_error and resp_rdata are nonzero only in RESP. resp_rdata is held until RESP exits, then cleared.
- req_valid outside IDLE is ignored, and the request is not queued.

## Timing
- Accept cycle = cycle 0. resp_valid is high in:
  - cycle 1 for misaligned requests;
  - cycle 2 for SW;
  - cycle 3 for loads;
  - cycle 4 for SB/SH.
- The next request can be accepted in the cycle after RESP. Maximum throughput is one request per (latency+1) cycles.
- Reset values:
  - state IDLE, req_ready=1;
  - resp_valid, resp_error, resp_rdata, mem_addr, mem_wr, mem_wdata all 0.
- Reset mid-operation:
  - The state machine and outputs return to reset values immediately and asynchronously.
  - An in-flight RMW never writes.
  - A write whose WR edge has not occurred is dropped; no partial write is possible.

## Structure
- Shared package lsu_pkg:
  - lsu_op_t enum (op encodings above);
  - lsu_state_t enum;
  - constants for lane width, 8 and 16.
- Sub-module lsu_lane: combinational, with two functions.
  - Extract: (word, addr[1:0], op) → sign-extended load value.
  - Merge: (word, wdata, addr[1:0], op) → store word.
- The FSM, registers and memory-port drive live in load_store_unit.

## Test plan
- Memory word 0x100 = 0x8899AABB. Expected responses:
  - LB 0x101 → resp_rdata 0xFFFFFFAA at cycle 3;
  - LB 0x100 → 0xFFFFFFBB;
  - LW 0x100 → 0x8899AABB;
  - mem_wr stays 0 throughout.
- Same word, halfword loads:
  - LH 0x102 → 0xFFFF8899;
  - LH 0x100 → 0xFFFFAABB.
- Sub-word stores on the same word:
  - SB 0x103 with wdata 0x12345677 → exactly one mem_wr cycle (cycle 3), word becomes 0x7799AABB, resp_valid at cycle 4;
  - then SH 0x100 with wdata 0x0000CAFE → word becomes 0x7799CAFE.
- SW 0x104 with wdata 0xDEADBEEF:
  - mem_wr in cycle 1 only, mem_addr 0x104;
  - resp_valid at cycle 2 with resp_rdata 0.
- Misaligned requests (LW 0x102, SH 0x101):
  - resp_valid and resp_error=1 at cycle 1, resp_rdata 0;
  - mem_wr and mem_addr stay 0.
- Reset asserted in MERGE of an SB, and separately with req_valid held high:
  - During the SB: outputs go to reset values at once, the memory word is unchanged, and no mem_wr occurs.
  - After release, with req_valid held high: back-to-back LWs are each accepted in the cycle after resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: op encodings, FSM states,
// lane widths and request classification.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW = 3'd0,
        OP_LH = 3'd1,
        OP_LB = 3'd2,
        OP_SW = 3'd4,
        OP_SH = 3'd5,
        OP_SB = 3'd6
    } lsu_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_RMW_RD,
        S_MERGE,
        S_WR,
        S_RESP
    } lsu_state_t;

    localparam int unsigned LANE_B_W = 8;
    localparam int unsigned LANE_H_W = 16;

    // Reserved encodings fall back to a word load.
    function automatic lsu_op_t decode_op(input logic [2:0] raw);
        case (raw)
            3'd1:    return OP_LH;
            3'd2:    return OP_LB;
            3'd4:    return OP_SW;
            3'd5:    return OP_SH;
            3'd6:    return OP_SB;
            default: return OP_LW;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW: return (lo != 2'b00);
            OP_LH, OP_SH: return lo[0];
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: sign-extending load extraction and sub-word store merge.
// Purely combinational; little-endian lane numbering.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  addr_lo_i,
    input  lsu_op_t     op_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  lo,
                                            input lsu_op_t     op);
        logic [LANE_B_W-1:0] b;
        logic [LANE_H_W-1:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   return {{24{b[LANE_B_W-1]}}, b};
            OP_LH:   return {{16{h[LANE_H_W-1]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word,
                                          input logic [31:0] wdata,
                                          input logic [1:0]  lo,
                                          input lsu_op_t     op);
        logic [31:0] m;
        m = word;
        case (op)
            OP_SB: begin
                case (lo)
                    2'd0:    m[7:0]   = wdata[LANE_B_W-1:0];
                    2'd1:    m[15:8]  = wdata[LANE_B_W-1:0];
                    2'd2:    m[23:16] = wdata[LANE_B_W-1:0];
                    default: m[31:24] = wdata[LANE_B_W-1:0];
                endcase
            end
            OP_SH: begin
                if (lo[1]) m[31:16] = wdata[LANE_H_W-1:0];
                else       m[15:0]  = wdata[LANE_H_W-1:0];
            end
            default: m = wdata;
        endcase
        return m;
    endfunction

    assign load_o  = extract(word_i, addr_lo_i, op_i);
    assign store_o = merge(word_i, wdata_i, addr_lo_i, op_i);

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store sequencer between the CPU datapath and a single-port
// synchronous data memory (read data valid one cycle after the address).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a request; memory port and response idle at 0
// S_RD     | load: word address presented to memory
// S_CAP    | load: extract/sign-extend lane from read data into response
// S_RMW_RD | SB/SH: word address presented for read-modify-write
// S_MERGE  | SB/SH: splice store lane(s) into read word, latch merged word
// S_WR     | single-cycle memory write strobe
// S_RESP   | one-cycle response pulse (data or misalignment error)
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    lsu_state_t  state_q, state_d;
    lsu_op_t     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] lane_load;
    logic [31:0] lane_store;
    lsu_op_t     req_op;

    assign req_op = decode_op(req_op_i);

    lsu_lane u_lane (
        .word_i    (mem_rdata_i),
        .wdata_i   (wdata_q),
        .addr_lo_i (addr_q[1:0]),
        .op_i      (op_q),
        .load_o    (lane_load),
        .store_o   (lane_store)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d = req_op;
                    // A misaligned request registers zeros so the memory port stays quiet.
                    if (is_misaligned(req_op, req_addr_i[1:0])) begin
                        err_d   = 1'b1;
                        addr_d  = '0;
                        wdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = req_addr_i;
                        wdata_d = req_wdata_i;
                        case (req_op)
                            OP_SW:        state_d = S_WR;
                            OP_SB, OP_SH: state_d = S_RMW_RD;
                            default:      state_d = S_RD;
                        endcase
                    end
                end
            end
            S_RD:     state_d = S_CAP;
            S_CAP: begin
                rdata_d = lane_load;
                state_d = S_RESP;
            end
            S_RMW_RD: state_d = S_MERGE;
            S_MERGE: begin
                wdata_d = lane_store;
                state_d = S_WR;
            end
            S_WR:     state_d = S_RESP;
            S_RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_error_o = (state_q == S_RESP) && err_q;
    assign resp_rdata_o = rdata_q;
    assign mem_wr_o     = (state_q == S_WR);
    assign mem_addr_o   = (state_q == S_IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    assign mem_wdata_o  = (state_q == S_IDLE) ? 32'h0 : wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous memory and a
// response scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          wr_total = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wrcyc;
        logic [31:0] wraddr;
    } exp_t;
    exp_t sb[$];

    load_store_unit dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_error_o (resp_error),
        .mem_addr_o   (mem_addr),
        .mem_wr_o     (mem_wr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= mem[mem_addr[9:2]];
        if (mem_wr === 1'b1) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_total <= wr_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input int exp_wrcyc,
                         input logic [31:0] exp_wraddr);
        exp_t        e;
        int          n;
        bit          got;
        int          wrc;
        int          wrcyc;
        logic [31:0] wra;
        bit          anz;
        @(negedge clk);
        chk({name, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        sb.push_back('{rd: exp_rd, err: exp_err, lat: exp_lat, wrcyc: exp_wrcyc, wraddr: exp_wraddr});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        n = 1; got = 0; wrc = 0; wrcyc = -1; wra = 32'h0; anz = 0;
        while (n <= 10 && !got) begin
            @(negedge clk);
            if (mem_wr === 1'b1) begin
                wrc++;
                wrcyc = n;
                wra = mem_addr;
            end
            if (mem_addr !== 32'h0) anz = 1;
            if (resp_valid === 1'b1) got = 1;
            else n++;
        end
        e = sb.pop_front();
        chk({name, "_resp_seen"}, {31'h0, got}, 32'h1);
        chk({name, "_rdata"}, resp_rdata, e.rd);
        chk({name, "_error"}, {31'h0, resp_error}, {31'h0, e.err});
        chk({name, "_latency"}, n, e.lat);
        chk({name, "_wr_count"}, wrc, (e.wrcyc >= 0) ? 1 : 0);
        if (e.wrcyc >= 0) begin
            chk({name, "_wr_cycle"}, wrcyc, e.wrcyc);
            chk({name, "_wr_addr"}, wra, e.wraddr);
        end
        if (e.err) chk({name, "_addr_quiet"}, {31'h0, anz}, 32'h0);
        @(negedge clk);
        chk({name, "_valid_drop"}, {31'h0, resp_valid}, 32'h0);
        chk({name, "_rdata_clear"}, resp_rdata, 32'h0);
    endtask

    initial begin
        int wr_before;
        int resp_cyc[3];
        bit got;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[64]   = 32'h8899AABB;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_memwr", {31'h0, mem_wr}, 32'h0);
        chk("rst_memaddr", mem_addr, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;

        issue("lb101", 3'd2, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 3, -1, 32'h0);
        issue("lb100", 3'd2, 32'h100, 32'h0, 32'hFFFFFFBB, 1'b0, 3, -1, 32'h0);
        issue("lw100", 3'd0, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 3, -1, 32'h0);
        issue("lh102", 3'd1, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 3, -1, 32'h0);
        issue("lh100", 3'd1, 32'h100, 32'h0, 32'hFFFFAABB, 1'b0, 3, -1, 32'h0);
        issue("sb103", 3'd6, 32'h103, 32'h12345677, 32'h0, 1'b0, 4, 3, 32'h100);
        chk("sb103_word", mem[64], 32'h7799AABB);
        issue("lb103", 3'd2, 32'h103, 32'h0, 32'h00000077, 1'b0, 3, -1, 32'h0);
        issue("sh100", 3'd5, 32'h100, 32'h0000CAFE, 32'h0, 1'b0, 4, 3, 32'h100);
        chk("sh100_word", mem[64], 32'h7799CAFE);
        issue("sw104", 3'd4, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'h104);
        chk("sw104_word", mem[65], 32'hDEADBEEF);
        issue("op3_104", 3'd3, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 3, -1, 32'h0);
        wr_before = wr_total;
        issue("lw102_mis", 3'd0, 32'h102, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
        issue("sh101_mis", 3'd5, 32'h101, 32'h5555, 32'h0, 1'b1, 1, -1, 32'h0);
        chk("mis_no_write", wr_total, wr_before);
        chk("mis_word", mem[64], 32'h7799CAFE);

        // SB interrupted by reset in MERGE, with a new request already held high.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd6;
        req_addr  = 32'h100;
        req_wdata = 32'h000000EE;
        @(posedge clk);
        #1;
        req_op    = 3'd0;
        req_addr  = 32'h100;
        @(negedge clk);
        @(negedge clk);
        wr_before = wr_total;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
        chk("rstmid_valid", {31'h0, resp_valid}, 32'h0);
        chk("rstmid_memwr", {31'h0, mem_wr}, 32'h0);
        chk("rstmid_memaddr", mem_addr, 32'h0);
        chk("rstmid_memwdata", mem_wdata, 32'h0);
        repeat (3) @(negedge clk);
        chk("rstmid_no_write", wr_total, wr_before);
        chk("rstmid_word", mem[64], 32'h7799CAFE);
        chk("rstmid_hold_ready", {31'h0, req_ready}, 32'h1);
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            int n;
            n = 0; got = 0;
            while (n < 12 && !got) begin
                @(negedge clk);
                if (resp_valid === 1'b1) got = 1;
                n++;
            end
            chk($sformatf("b2b%0d_seen", k), {31'h0, got}, 32'h1);
            chk($sformatf("b2b%0d_rdata", k), resp_rdata, 32'h7799CAFE);
            resp_cyc[k] = cyc;
            @(negedge clk);
            chk($sformatf("b2b%0d_ready_after", k), {31'h0, req_ready}, 32'h1);
            @(negedge clk);
            chk($sformatf("b2b%0d_accepted", k), {31'h0, req_ready}, 32'h0);
        end
        chk("b2b_gap0", resp_cyc[1] - resp_cyc[0], 4);
        chk("b2b_gap1", resp_cyc[2] - resp_cyc[1], 4);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
